// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave
// AXI4-Lite completer for the HBM heating fabric control link
// (11-bit byte address, 32-bit data).
// It holds NUM_RW read/write control registers that drive fabric logic, and it
// exposes NUM_RO read-only status words sampled from fabric inputs.
// Word index = addr[10:2]:
//   0 .. NUM_RW-1                  RW registers
//   NUM_RW .. NUM_RW+NUM_RO-1      RO status words
//   anything above                 unmapped, answered with SLVERR
// The write channel and the read channel are independent FSMs.
// Each FSM handles one outstanding transaction.
//
// Ports:
//   axi_aclk, axi_areset      clock; synchronous active-high reset
//   axi_aw*/axi_w*/axi_b*     write address, write data and write response channels
//   axi_ar*/axi_r*            read address and read data channels
//   reg_out      [NUM_RW*32]  RW register contents; word i is at [32i+31:32i]
//   status_in    [NUM_RO*32]  RO status words, packed the same way
//   reg_wr_pulse [NUM_RW]     one-cycle strobe per RW register
//
// Optional build macro AXI_SLAVE_WR_PULSE_EN:
//   When defined, reg_wr_pulse[i] pulses together with the rise of bvalid
//   whenever a write commits at least one byte to RW register i.
//   When undefined, reg_wr_pulse is tied to zero.
module axi_lite_reg_slave #(
  parameter int          NUM_RW       = 4,
  parameter int          NUM_RO       = 4,
  parameter logic [31:0] RW_RESET_VAL = 32'h0000_0000
) (
  input  logic                   axi_aclk,
  input  logic                   axi_areset,
  input  logic [10:0]            axi_awaddr,
  input  logic                   axi_awvalid,
  output logic                   axi_awready,
  input  logic [31:0]            axi_wdata,
  input  logic [3:0]             axi_wstrb,
  input  logic                   axi_wvalid,
  output logic                   axi_wready,
  output logic [1:0]             axi_bresp,
  output logic                   axi_bvalid,
  input  logic                   axi_bready,
  input  logic [10:0]            axi_araddr,
  input  logic                   axi_arvalid,
  output logic                   axi_arready,
  output logic [31:0]            axi_rdata,
  output logic [1:0]             axi_rresp,
  output logic                   axi_rvalid,
  input  logic                   axi_rready,
  output logic [NUM_RW*32-1:0]   reg_out,
  input  logic [NUM_RO*32-1:0]   status_in,
  output logic [NUM_RW-1:0]      reg_wr_pulse
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [8:0] RW_END      = 9'(NUM_RW);

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t   wr_state, wr_state_d;
  rd_state_t   rd_state, rd_state_d;

  logic [31:0] rw_regs [NUM_RW];

  logic        aw_held, aw_held_d, w_held, w_held_d;
  logic [8:0]  aw_idx_q, aw_idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awready_d, wready_d, bvalid_d;
  logic [1:0]  bresp_d;
  logic        wr_commit;

  logic        arready_d, rvalid_d;
  logic [31:0] rdata_d, rd_word;
  logic [1:0]  rresp_d;
  logic        rd_err;

  logic        aw_hs, w_hs, ar_hs;
  logic [8:0]  wr_idx, rd_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_is_rw;

  // The byte-offset bits of both addresses are ignored by design.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{axi_awaddr[1:0], axi_araddr[1:0]};

  assign aw_hs = axi_awvalid & axi_awready;
  assign w_hs  = axi_wvalid & axi_wready;
  assign ar_hs = axi_arvalid & axi_arready;

  // A beat that has not been latched yet is taken straight from the bus.
  // This lets the commit happen on the same edge as the later handshake.
  assign wr_idx   = aw_held ? aw_idx_q : axi_awaddr[10:2];
  assign wr_data  = w_held ? wdata_q : axi_wdata;
  assign wr_strb  = w_held ? wstrb_q : axi_wstrb;
  assign wr_is_rw = (wr_idx < RW_END);
  assign rd_idx   = axi_araddr[10:2];

  for (genvar g = 0; g < NUM_RW; g++) begin : g_reg_out
    assign reg_out[32*g +: 32] = rw_regs[g];
  end

  always_comb begin
    wr_state_d = wr_state;
    aw_held_d  = aw_held;
    w_held_d   = w_held;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awready_d  = axi_awready;
    wready_d   = axi_wready;
    bvalid_d   = axi_bvalid;
    bresp_d    = axi_bresp;
    wr_commit  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_idx_d  = axi_awaddr[10:2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = axi_wdata;
          wstrb_d  = axi_wstrb;
        end
        awready_d = ~aw_held_d;
        wready_d  = ~w_held_d;
        if (aw_held_d && w_held_d) begin
          wr_commit  = 1'b1;
          wr_state_d = WR_RESP;
          bvalid_d   = 1'b1;
          bresp_d    = wr_is_rw ? RESP_OKAY : RESP_SLVERR;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
        end
      end
      WR_RESP: begin
        if (axi_bready) begin
          wr_state_d = WR_IDLE;
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wr_state    <= WR_IDLE;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_idx_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= RESP_OKAY;
    end else begin
      wr_state    <= wr_state_d;
      aw_held     <= aw_held_d;
      w_held      <= w_held_d;
      aw_idx_q    <= aw_idx_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      axi_awready <= awready_d;
      axi_wready  <= wready_d;
      axi_bvalid  <= bvalid_d;
      axi_bresp   <= bresp_d;
    end
  end

  // Byte-lane update of the addressed RW register on commit.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      for (int i = 0; i < NUM_RW; i++) rw_regs[i] <= RW_RESET_VAL;
    end else if (wr_commit && wr_is_rw) begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (wr_idx == 9'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) rw_regs[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

`ifdef AXI_SLAVE_WR_PULSE_EN
  logic [NUM_RW-1:0] pulse_q;

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < NUM_RW; i++) begin
        pulse_q[i] <= wr_commit && wr_is_rw && (wr_idx == 9'(i)) && (|wr_strb);
      end
    end
  end

  assign reg_wr_pulse = pulse_q;
`else
  assign reg_wr_pulse = '0;
`endif

  // Read mux: RW registers first, then status words; anything else reads
  // as zero with an error response.
  always_comb begin
    rd_word = '0;
    rd_err  = 1'b1;
    for (int i = 0; i < NUM_RW; i++) begin
      if (rd_idx == 9'(i)) begin
        rd_word = rw_regs[i];
        rd_err  = 1'b0;
      end
    end
    for (int i = 0; i < NUM_RO; i++) begin
      if (rd_idx == 9'(NUM_RW + i)) begin
        rd_word = status_in[32*i +: 32];
        rd_err  = 1'b0;
      end
    end
  end

  always_comb begin
    rd_state_d = rd_state;
    arready_d  = axi_arready;
    rvalid_d   = axi_rvalid;
    rdata_d    = axi_rdata;
    rresp_d    = axi_rresp;
    case (rd_state)
      RD_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rd_state_d = RD_DATA;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = rd_word;
          rresp_d    = rd_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
      RD_DATA: begin
        if (axi_rready) begin
          rd_state_d = RD_IDLE;
          arready_d  = 1'b1;
          rvalid_d   = 1'b0;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      rd_state    <= RD_IDLE;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rdata   <= '0;
      axi_rresp   <= RESP_OKAY;
    end else begin
      rd_state    <= rd_state_d;
      axi_arready <= arready_d;
      axi_rvalid  <= rvalid_d;
      axi_rdata   <= rdata_d;
      axi_rresp   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb_axi_lite_reg_slave
// Self-checking bench for axi_lite_reg_slave.
// A transaction-level model predicts all DUT outputs on every cycle:
//   - handshake readiness
//   - response valid/resp/data
//   - register contents
//   - write pulses
// Directed scenarios come first and carry literal expectations.
// A randomized phase follows.
// Honors AXI_SLAVE_WR_PULSE_EN the same way the design does.
module tb_axi_lite_reg_slave;

  localparam int          NUM_RW  = 4;
  localparam int          NUM_RO  = 4;
  localparam logic [31:0] RST_VAL = 32'h0000_0000;
`ifdef AXI_SLAVE_WR_PULSE_EN
  localparam bit PULSE_ON = 1'b1;
`else
  localparam bit PULSE_ON = 1'b0;
`endif

  logic                  axi_aclk = 1'b0;
  logic                  axi_areset;
  logic [10:0]           axi_awaddr;
  logic                  axi_awvalid;
  logic                  axi_awready;
  logic [31:0]           axi_wdata;
  logic [3:0]            axi_wstrb;
  logic                  axi_wvalid;
  logic                  axi_wready;
  logic [1:0]            axi_bresp;
  logic                  axi_bvalid;
  logic                  axi_bready;
  logic [10:0]           axi_araddr;
  logic                  axi_arvalid;
  logic                  axi_arready;
  logic [31:0]           axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rvalid;
  logic                  axi_rready;
  logic [NUM_RW*32-1:0]  reg_out;
  logic [NUM_RO*32-1:0]  status_in;
  logic [NUM_RW-1:0]     reg_wr_pulse;

  int checks = 0;
  int errors = 0;

  axi_lite_reg_slave #(
    .NUM_RW(NUM_RW), .NUM_RO(NUM_RO), .RW_RESET_VAL(RST_VAL)
  ) dut (
    .axi_aclk(axi_aclk), .axi_areset(axi_areset),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready), .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .reg_out(reg_out),
    .status_in(status_in), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 axi_aclk = ~axi_aclk;

  // Reference model state: what the completer must have done so far.
  logic [31:0]       m_regs [NUM_RW];
  bit                m_valid = 1'b0;
  bit                m_have_aw, m_have_w, m_in_b, m_in_r;
  bit                m_awready, m_wready, m_arready;
  logic [10:0]       m_aw_addr;
  logic [31:0]       m_wdata, m_rdata;
  logic [3:0]        m_wstrb;
  logic [1:0]        m_bresp, m_rresp;
  logic [NUM_RW-1:0] m_pulse;
  bit                hs_aw, hs_w, hs_ar;

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // Model update on every active edge.
  // The read is resolved before the write commit, so a read that lands on
  // the same edge as a commit sees the old register value.
  always @(posedge axi_aclk) begin
    int idx;
    hs_aw = 1'b0;
    hs_w  = 1'b0;
    hs_ar = 1'b0;
    if (axi_areset) begin
      for (int i = 0; i < NUM_RW; i++) m_regs[i] = RST_VAL;
      {m_have_aw, m_have_w, m_in_b, m_in_r} = '0;
      {m_awready, m_wready, m_arready} = '0;
      m_bresp = 2'b00;
      m_rresp = 2'b00;
      m_rdata = '0;
      m_pulse = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_in_r) begin
        if (axi_rready) m_in_r = 1'b0;
      end else if (axi_arvalid && m_arready) begin
        hs_ar  = 1'b1;
        m_in_r = 1'b1;
        idx = int'(axi_araddr[10:2]);
        if (idx < NUM_RW) begin
          m_rdata = m_regs[idx];
          m_rresp = 2'b00;
        end else if (idx < NUM_RW + NUM_RO) begin
          m_rdata = status_in[(idx - NUM_RW)*32 +: 32];
          m_rresp = 2'b00;
        end else begin
          m_rdata = '0;
          m_rresp = 2'b10;
        end
      end
      m_pulse = '0;
      if (m_in_b) begin
        if (axi_bready) m_in_b = 1'b0;
      end else begin
        if (axi_awvalid && m_awready) begin
          hs_aw = 1'b1;
          m_have_aw = 1'b1;
          m_aw_addr = axi_awaddr;
        end
        if (axi_wvalid && m_wready) begin
          hs_w = 1'b1;
          m_have_w = 1'b1;
          m_wdata = axi_wdata;
          m_wstrb = axi_wstrb;
        end
        if (m_have_aw && m_have_w) begin
          idx = int'(m_aw_addr[10:2]);
          if (idx < NUM_RW) begin
            m_regs[idx] = (m_regs[idx] & ~strb_mask(m_wstrb)) | (m_wdata & strb_mask(m_wstrb));
            m_bresp = 2'b00;
            if (PULSE_ON && m_wstrb != 4'h0) m_pulse[idx] = 1'b1;
          end else begin
            m_bresp = 2'b10;
          end
          m_in_b = 1'b1;
          m_have_aw = 1'b0;
          m_have_w = 1'b0;
        end
      end
      m_awready = !m_in_b && !m_have_aw;
      m_wready  = !m_in_b && !m_have_w;
      m_arready = !m_in_r;
    end
  end

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge axi_aclk) begin
    if (m_valid) begin
      check_output("awready", axi_awready, m_awready);
      check_output("wready", axi_wready, m_wready);
      check_output("arready", axi_arready, m_arready);
      check_output("bvalid", axi_bvalid, m_in_b);
      check_output("rvalid", axi_rvalid, m_in_r);
      if (m_in_b) check_output("bresp", axi_bresp, m_bresp);
      if (m_in_r) begin
        check_output("rdata", axi_rdata, m_rdata);
        check_output("rresp", axi_rresp, m_rresp);
      end
      for (int i = 0; i < NUM_RW; i++)
        check_output($sformatf("reg_out[%0d]", i), reg_out[32*i +: 32], m_regs[i]);
      check_output("reg_wr_pulse", reg_wr_pulse, m_pulse);
    end
  end

  function automatic logic [10:0] rand_addr();
    int w;
    w = $urandom_range(0, NUM_RW + NUM_RO + 1);
    if ($urandom_range(0, 7) == 0) w = 511;
    return {9'(w), 2'($urandom_range(0, 3))};
  endfunction

  // One cycle of random traffic; a valid is held until the model saw it taken.
  task automatic apply_stimulus();
    if (axi_awvalid && hs_aw) axi_awvalid = 1'b0;
    if (axi_wvalid && hs_w)   axi_wvalid  = 1'b0;
    if (axi_arvalid && hs_ar) axi_arvalid = 1'b0;
    if (!axi_awvalid && $urandom_range(0, 2) == 0) begin
      axi_awvalid = 1'b1;
      axi_awaddr  = rand_addr();
    end
    if (!axi_wvalid && $urandom_range(0, 2) == 0) begin
      axi_wvalid = 1'b1;
      axi_wdata  = $urandom;
      axi_wstrb  = 4'($urandom_range(0, 15));
    end
    if (!axi_arvalid && $urandom_range(0, 2) == 0) begin
      axi_arvalid = 1'b1;
      axi_araddr  = rand_addr();
    end
    axi_bready = 1'($urandom_range(0, 1));
    axi_rready = 1'($urandom_range(0, 1));
    status_in  = {$urandom, $urandom, $urandom, $urandom};
    axi_areset = ($urandom_range(0, 299) == 0);
    if (axi_areset) begin
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
      axi_arvalid = 1'b0;
    end
    @(negedge axi_aclk);
  endtask

  initial begin
    axi_areset  = 1'b1;
    axi_awaddr  = '0;
    axi_awvalid = 1'b0;
    axi_wdata   = '0;
    axi_wstrb   = '0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    axi_araddr  = '0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    status_in   = '0;
    repeat (2) @(negedge axi_aclk);
    check_output("rst_bvalid", axi_bvalid, 1'b0);
    check_output("rst_rvalid", axi_rvalid, 1'b0);
    check_output("rst_awready", axi_awready, 1'b0);
    check_output("rst_reg_out", reg_out, 128'h0);
    axi_areset = 1'b0;
    @(negedge axi_aclk);
    check_output("ready_after_rst", {axi_awready, axi_wready, axi_arready}, 3'b111);

    // AW and W together to word 1.
    axi_awaddr = 11'h004; axi_awvalid = 1'b1;
    axi_wdata = 32'hA5A5_1234; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
    axi_bready = 1'b1;
    @(negedge axi_aclk);
    check_output("t1_bvalid", axi_bvalid, 1'b1);
    check_output("t1_bresp", axi_bresp, 2'b00);
    check_output("t1_reg1", reg_out[63:32], 32'hA5A5_1234);
    check_output("t1_pulse", reg_wr_pulse, PULSE_ON ? 4'b0010 : 4'b0000);
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    @(negedge axi_aclk);
    check_output("t1_bvalid_done", axi_bvalid, 1'b0);
    check_output("t1_pulse_done", reg_wr_pulse, 4'b0000);

    // W three cycles ahead of AW, partial strobes to word 0.
    axi_wdata = 32'hFFFF_FFFF; axi_wstrb = 4'b0101; axi_wvalid = 1'b1;
    @(negedge axi_aclk);
    check_output("t2_wready_low", axi_wready, 1'b0);
    check_output("t2_no_bvalid", axi_bvalid, 1'b0);
    axi_wvalid = 1'b0;
    repeat (2) @(negedge axi_aclk);
    axi_awaddr = 11'h000; axi_awvalid = 1'b1;
    @(negedge axi_aclk);
    check_output("t2_bvalid", axi_bvalid, 1'b1);
    check_output("t2_reg0", reg_out[31:0], 32'h00FF_00FF);
    axi_awvalid = 1'b0;
    @(negedge axi_aclk);

    // Status read under read-data backpressure.
    status_in[31:0] = 32'hCAFE_F00D;
    axi_araddr = 11'h010; axi_arvalid = 1'b1; axi_rready = 1'b0;
    @(negedge axi_aclk);
    axi_arvalid = 1'b0;
    status_in[31:0] = 32'h0;
    for (int c = 0; c < 5; c++) begin
      check_output("t3_rvalid", axi_rvalid, 1'b1);
      check_output("t3_rdata", axi_rdata, 32'hCAFE_F00D);
      check_output("t3_rresp", axi_rresp, 2'b00);
      check_output("t3_arready", axi_arready, 1'b0);
      @(negedge axi_aclk);
    end
    axi_rready = 1'b1;
    @(negedge axi_aclk);
    check_output("t3_rvalid_done", axi_rvalid, 1'b0);
    check_output("t3_arready_back", axi_arready, 1'b1);

    // Write to an RO word, then read and write an unmapped word.
    axi_awaddr = 11'h010; axi_awvalid = 1'b1;
    axi_wdata = 32'h1234_5678; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
    @(negedge axi_aclk);
    check_output("t4_ro_bresp", axi_bresp, 2'b10);
    check_output("t4_regs_kept", reg_out, 128'h0000_0000_0000_0000_A5A5_1234_00FF_00FF);
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    @(negedge axi_aclk);
    axi_araddr = 11'h7FC; axi_arvalid = 1'b1;
    @(negedge axi_aclk);
    check_output("t4_unmapped_rdata", axi_rdata, 32'h0);
    check_output("t4_unmapped_rresp", axi_rresp, 2'b10);
    axi_arvalid = 1'b0;
    @(negedge axi_aclk);
    axi_awaddr = 11'h7FC; axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    @(negedge axi_aclk);
    check_output("t4_unmapped_bresp", axi_bresp, 2'b10);
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    @(negedge axi_aclk);

    // Read of word 2 on the same edge that commits a write to it.
    axi_awaddr = 11'h008; axi_awvalid = 1'b1;
    axi_wdata = 32'h1111_1111; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
    axi_araddr = 11'h008; axi_arvalid = 1'b1;
    @(negedge axi_aclk);
    check_output("t5_old_rdata", axi_rdata, 32'h0);
    check_output("t5_reg2", reg_out[95:64], 32'h1111_1111);
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
    @(negedge axi_aclk);
    axi_arvalid = 1'b1;
    @(negedge axi_aclk);
    check_output("t5_new_rdata", axi_rdata, 32'h1111_1111);
    axi_arvalid = 1'b0;
    @(negedge axi_aclk);

    // Reset while a write response is stalled.
    axi_bready = 1'b0;
    axi_awaddr = 11'h00C; axi_awvalid = 1'b1;
    axi_wdata = 32'hDEAD_BEEF; axi_wvalid = 1'b1;
    @(negedge axi_aclk);
    check_output("t6_bvalid", axi_bvalid, 1'b1);
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    @(negedge axi_aclk);
    check_output("t6_bvalid_stall", axi_bvalid, 1'b1);
    axi_areset = 1'b1;
    @(negedge axi_aclk);
    check_output("t6_bvalid_rst", axi_bvalid, 1'b0);
    check_output("t6_reg_out_rst", reg_out, 128'h0);
    axi_areset = 1'b0;
    @(negedge axi_aclk);
    check_output("t6_ready_after", {axi_awready, axi_wready, axi_arready}, 3'b111);
    axi_bready = 1'b1;

    for (int n = 0; n < 3000; n++) apply_stimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
- AXI4-Lite responder: the completer side of the 11-bit-address, 32-bit-data control link whose initiator sits in the HBM heating fabric.
- Contains a bank of NUM_RW read/write control registers driven out to fabric logic, plus NUM_RO read-only status words sampled from fabric inputs.
- Write and read channels run as independent FSMs. Each handles one outstanding transaction; there is no burst support.

Parameters:
- NUM_RW, 4: number of RW registers, at word indices 0..NUM_RW-1.
- NUM_RO, 4: number of RO status words, at word indices NUM_RW..NUM_RW+NUM_RO-1.
- RW_RESET_VAL, 32'h0000_0000: reset value of every RW register.

Ports:
- axi_aclk  in  1  clock.
- axi_areset  in  1  synchronous reset, active-high.
- axi_awaddr  in  11  write address.
- axi_awvalid  in  1.
- axi_awready  out  1.
- axi_wdata  in  32.
- axi_wstrb  in  4  byte enables.
- axi_wvalid  in  1.
- axi_wready  out  1.
- axi_bresp  out  2.
- axi_bvalid  out  1.
- axi_bready  in  1.
- axi_araddr  in  11.
- axi_arvalid  in  1.
- axi_arready  out  1.
- axi_rdata  out  32.
- axi_rresp  out  2.
- axi_rvalid  out  1.
- axi_rready  in  1.
- reg_out  out  NUM_RW*32  RW register contents; word i is at bits [32i+31:32i].
- status_in  in  NUM_RO*32  RO status words, same packing.
- reg_wr_pulse  out  NUM_RW  one-cycle write strobe per RW register (see Optional Feature).

Behaviour:
- Clock and reset:
  - One clock, axi_aclk.
  - axi_areset is synchronous and active-high; it takes priority over everything else.
- Reset values:
  - axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid = 0.
  - axi_bresp, axi_rresp = 2'b00; axi_rdata = 0.
  - reg_out = RW_RESET_VAL in every word; reg_wr_pulse = 0.
- Reset mid-transaction: any in-flight transaction is dropped with no B or R response. Both FSMs return to IDLE.
- Address decode:
  - Word index = addr[10:2]; addr[1:0] are ignored.
  - idx < NUM_RW selects an RW register.
  - NUM_RW ≤ idx < NUM_RW+NUM_RO selects an RO word.
  - Any higher index is unmapped.
- Write FSM, states WR_IDLE → WR_RESP:
  - WR_IDLE:
    - axi_awready = 1 until the AW beat has been captured; axi_wready = 1 until the W beat has been captured.
    - AW and W may arrive in either order or in the same cycle.
    - Each beat is latched on its handshake (valid & ready); once latched, that channel's ready drops.
  - When both beats are held:
    - On the next edge, commit the write and move to WR_RESP with axi_bvalid = 1.
    - Latency: bvalid rises 1 cycle after the later of the two handshakes.
  - Commit rules:
    - RW target: update only the bytes whose wstrb bit is set; bresp = 2'b00 (OKAY). wstrb = 0 changes nothing and still returns OKAY.
    - RO or unmapped target: no state change; bresp = 2'b10 (SLVERR).
  - WR_RESP:
    - awready = wready = 0.
    - bvalid and bresp are held until bready is seen; then return to WR_IDLE.
    - awready and wready rise again in the next cycle.
- Read FSM, states RD_IDLE → RD_DATA:
  - RD_IDLE:
    - axi_arready = 1.
    - On the AR handshake, register rdata and rresp from the value present before that edge, then enter RD_DATA.
    - rresp is OKAY for RW and RO words. Unmapped reads return rdata = 0 with rresp = SLVERR.
  - RD_DATA:
    - arready = 0; rvalid = 1.
    - rdata and rresp are held stable until rready is seen; then return to RD_IDLE.
    - Latency: rvalid rises 1 cycle after the AR handshake.
  - status_in is sampled only at the AR handshake.
- Simultaneous events:
  - Read and write run fully concurrently.
  - If the AR handshake edge coincides with a commit edge to the same register, the read returns the pre-write value.
- Backpressure: while bready or rready is held low, the matching FSM stalls indefinitely with its outputs stable.

Optional Feature:
- Macro: AXI_SLAVE_WR_PULSE_EN.
- Defined: reg_wr_pulse[i] = 1 for exactly one cycle, coincident with bvalid rising, when a commit to RW register i has at least one wstrb bit set. A write with wstrb = 0 produces no pulse.
- Undefined: reg_wr_pulse is tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
- AW and W in the same cycle, addr 0x004, wdata 0xA5A5_1234, wstrb F, bready = 1 → bvalid 1 cycle after handshake, bresp 00, reg_out word1 = 0xA5A5_1234, reg_wr_pulse = 4'b0010 for 1 cycle (macro defined).
- W issued 3 cycles before AW, addr 0x000, wdata 0xFFFF_FFFF, wstrb 4'b0101, reg0 previously 0 → reg0 = 0x00FF_00FF; bvalid 1 cycle after the AW handshake.
- status_in word0 = 0xCAFE_F00D, read addr 0x010 with rready held low for 5 cycles → rvalid held 5 cycles, rdata 0xCAFE_F00D stable, rresp 00; arready = 0 until the R handshake.
- Write to addr 0x010 (RO) → bresp 10, status path unchanged. Read and write to addr 0x7FC (unmapped) → rdata 0 with rresp 10; bresp 10.
- Read of reg2 whose AR handshake edge coincides with a commit of 0x1111_1111 to reg2 (old value 0x0) → rdata = 0x0; a following read returns 0x1111_1111.
- Assert axi_areset while in WR_RESP with bready = 0 → bvalid = 0 on the next cycle, reg_out = RW_RESET_VAL, awready = wready = arready = 1 in the cycle after reset deasserts.
